// File: rtl/instr_encoder_loader.sv
// Boot-time program writer: encodes decoded RV32I field bundles and streams them into imem.
// Optional LOADER_CHECKSUM_EN adds a running 32-bit sum of the words written this session.
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [2:0]            in_fmt,
    input  logic [6:0]            in_opcode,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_rs1,
    input  logic [4:0]            in_rs2,
    input  logic [2:0]            in_funct3,
    input  logic [6:0]            in_funct7,
    input  logic [31:0]           in_imm,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    input  logic                  imem_ack,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           checksum
);
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  last_q, last_d;
    logic                  err_q, err_d;
    logic [31:0]           enc_word;
    logic                  enc_err;

    // Format codes mirror the decoder's imm_type, with R-type appended
    always_comb begin
        enc_word = 32'h0000_0013;
        enc_err  = 1'b0;
        case (in_fmt)
            3'b000: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'b001: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'b010: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                enc_err  = in_imm[0];
            end
            3'b011: enc_word = {in_imm[31:12], in_rd, in_opcode};
            3'b100: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                enc_err  = in_imm[0];
            end
            3'b101: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            default: enc_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        last_d  = last_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    addr_d  = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wdata_d = enc_word;
                    last_d  = in_last;
                    err_d   = err_q | enc_err;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (imem_ack) begin
                    count_d = count_q + 1'b1;
                    addr_d  = addr_q + 1'b1;
                    if (last_q) begin
                        state_d = DONE;
                    end else if (addr_q == '1) begin
                        // Next address would wrap onto already-written words
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= BASE;
            wdata_q <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == IDLE || state_q == DONE) && start)
            csum_d = '0;
        else if (state_q == WRITE && imem_ack)
            csum_d = csum_q + wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign in_ready   = (state_q == LOAD);
    assign imem_we    = (state_q == WRITE);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = (state_q == DONE);
    assign error      = err_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: the driver queues expected {addr, word}; a monitor pops on each acked write.
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0, imem_ack = 1'b1;
    logic [2:0]  in_fmt = '0, in_funct3 = '0;
    logic [6:0]  in_opcode = '0, in_funct7 = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        in_ready, imem_we, done, error;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata, checksum;
    logic [10:0] count;

    // Small-address instance for the overflow case
    logic        start_s = 1'b0, valid_s = 1'b0;
    logic        s_ready, s_we, s_done, s_error;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata, s_csum;
    logic [2:0]  s_count;

    int total = 0, bad = 0;
    logic [41:0] sb[$];

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_WIDTH(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ack(imem_ack), .count(count), .done(done), .error(error), .checksum(checksum));

    instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(valid_s), .in_ready(s_ready),
        .in_last(1'b0), .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_imm(in_imm), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .imem_ack(1'b1), .count(s_count), .done(s_done), .error(s_error), .checksum(s_csum));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && imem_we && imem_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {22'd0, imem_addr, imem_wdata}, 64'hDEAD);
            end else begin
                logic [41:0] e;
                e = sb.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(e[41:32]));
                chk("wr_data", 64'(imem_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last,
                        input logic [9:0] ea, input logic [31:0] ew);
        int n = 0;
        in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = r1; in_rs2 = r2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("ready_timeout", 64'(in_ready), 64'd1);
        sb.push_back({ea, ew});
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    initial begin
        logic [9:0]  ha;
        logic [31:0] hw;
        int nw;
        #12;
        chk("rst_ready", 64'(in_ready), 0);
        chk("rst_we", 64'(imem_we), 0);
        chk("rst_addr", 64'(imem_addr), 0);
        chk("rst_wdata", 64'(imem_wdata), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_flags", {61'd0, done, error, 1'b0}, 0);
        chk("rst_csum", 64'(checksum), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Session 1: I, S, B, J
        pulse_start();
        send(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b0, 10'd0, 32'h0050_0093);
        chk("tp_ready_lo", 64'(in_ready), 0);
        chk("tp_we", 64'(imem_we), 1);
        @(posedge clk); #1;
        chk("tp_ready_hi", 64'(in_ready), 1);
        send(3'b001, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b0, 10'd1, 32'h0020_A423);
        send(3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFF_FFFC, 1'b0, 10'd2, 32'hFE20_8EE3);
        send(3'b100, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8, 1'b1, 10'd3, 32'h0080_00EF);
        @(posedge clk); #1;
        chk("s1_done", 64'(done), 1);
        chk("s1_count", 64'(count), 4);
        chk("s1_error", 64'(error), 0);
`ifdef LOADER_CHECKSUM_EN
        chk("s1_csum", 64'(checksum), 64'h0000_0000_FF11_3488);
`else
        chk("s1_csum", 64'(checksum), 0);
`endif

        // Session 2: U, R with stalled ack, illegal fmt, misaligned B
        pulse_start();
        chk("s2_count_clr", 64'(count), 0);
        send(3'b011, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 1'b0, 10'd0, 32'h1234_52B7);
        chk("s2_err_u", 64'(error), 0);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        send(3'b101, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 32'd0, 1'b0, 10'd1, 32'h4020_81B3);
        ha = imem_addr; hw = imem_wdata;
        for (int i = 0; i < 3; i++) begin
            chk("stall_we", 64'(imem_we), 1);
            chk("stall_ready", 64'(in_ready), 0);
            chk("stall_addr", 64'(imem_addr), 64'(ha));
            chk("stall_data", 64'(imem_wdata), 64'(hw));
            @(posedge clk); #1;
        end
        imem_ack = 1'b1;
        @(posedge clk); #1;
        chk("stall_done_ready", 64'(in_ready), 1);
        send(3'b110, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1'b0, 10'd2, 32'h0000_0013);
        chk("illegal_err", 64'(error), 1);
        send(3'b010, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd7, 1'b1, 10'd3, 32'h0000_0363);
        @(posedge clk); #1;
        chk("s2_done", 64'(done), 1);
        chk("s2_count", 64'(count), 4);
        chk("s2_err_sticky", 64'(error), 1);
        pulse_start();
        chk("err_clr_on_start", 64'(error), 0);

        // Session 3: misaligned B alone, error from imm[0]
        send(3'b010, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd7, 1'b1, 10'd0, 32'h0000_0363);
        chk("b_odd_err", 64'(error), 1);
        @(posedge clk); #1;

        // Overflow on a 4-word memory
        in_fmt = 3'b000; in_opcode = 7'b0010011; in_rd = 5'd1; in_imm = 32'd1;
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        valid_s = 1'b1;
        nw = 0;
        repeat (20) begin
            @(negedge clk);
            if (s_we) nw++;
        end
        valid_s = 1'b0;
        #1;
        chk("ovf_writes", 64'(nw), 4);
        chk("ovf_done", 64'(s_done), 1);
        chk("ovf_count", 64'(s_count), 4);
        chk("ovf_error", 64'(s_error), 1);

        // Asynchronous reset during WRITE
        @(posedge clk); #1;
        pulse_start();
        imem_ack = 1'b0;
        send(3'b000, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b0, 10'd0, 32'h0050_0093);
        chk("pre_rst_we", 64'(imem_we), 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_we", 64'(imem_we), 0);
        chk("arst_addr", 64'(imem_addr), 0);
        chk("arst_wdata", 64'(imem_wdata), 0);
        chk("arst_flags", {61'd0, done, error, in_ready}, 0);
        imem_ack = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        send(3'b000, 7'b0010011, 5'd2, 5'd1, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 1'b1, 10'd0, 32'hFFF0_8113);
        @(posedge clk); #1;
        chk("post_rst_count", 64'(count), 1);
        chk("sb_empty", 64'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Boot-time program writer for the single-cycle core: accepts decoded instruction fields over a valid/ready stream and encodes them into 32-bit RV32I words.
- Writes the words sequentially into instruction memory.
- It is the encoding counterpart of the main control decoder. Its format codes match the decoder's imm_type encoding, extended with R-type.
- Sits between the test/boot host interface and the instruction memory write port. The core is held off until done.

Parameters:
ADDR_WIDTH, 10, instruction-memory word-address width
BASE_ADDR, 0, first word address written after start

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a load session
in_valid  input  1  field bundle valid
in_ready  output  1  block can accept a bundle
in_last  input  1  bundle is the final instruction
in_fmt  input  3  000=I, 001=S, 010=B, 011=U, 100=J, 101=R, 110/111 illegal
in_opcode  input  7  opcode[6:0]
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (R only)
in_imm  input  32  sign-extended immediate (byte offset for B/J; U uses imm[31:12])
imem_we  output  1  write request
imem_addr  output  ADDR_WIDTH  word address
imem_wdata  output  32  encoded instruction
imem_ack  input  1  write accepted this cycle
count  output  ADDR_WIDTH+1  words written this session
done  output  1  session complete (level)
error  output  1  sticky: illegal format, misaligned B/J imm, or address overflow
checksum  output  32  see Optional Feature

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE; in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, done=0, error=0, checksum=0. Reset mid-write drops imem_we immediately; the in-flight word is lost.
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE: in_ready=0. On start, go to LOAD with imem_addr=BASE_ADDR, count=0, error=0, checksum=0.
- LOAD: in_ready=1. On in_valid&in_ready, register the encoded word into imem_wdata, latch in_last, go to WRITE.
- WRITE: in_ready=0, imem_we=1. imem_addr and imem_wdata stay stable until imem_ack.
- On imem_ack: count+1 and imem_addr+1. Then:
  - in_last latched: go to DONE.
  - imem_addr was all-ones (next address would wrap): set error, go to DONE.
  - otherwise: go to LOAD.
- Throughput: at best one word per 2 cycles (accept at cycle N, we at N+1 with ack, in_ready again at N+2).
- DONE: done=1, in_ready=0. start restarts the session as from IDLE. start in LOAD/WRITE is ignored.
- Encoding, concatenated MSB to LSB:
  - I: imm[11:0],rs1,f3,rd,op
  - S: imm[11:5],rs2,rs1,f3,imm[4:0],op
  - B: imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op
  - U: imm[31:12],rd,op
  - J: imm[20],imm[10:1],imm[11],imm[19:12],rd,op
  - R: f7,rs2,rs1,f3,rd,op
- Unused fields per format are ignored. Upper immediate bits beyond each format's range are discarded with no range check.
- Illegal fmt: write 32'h00000013 (NOP) and set error.
- B/J with imm[0]=1: encode normally (bit 0 is not representable) and set error.
- error is sticky until start or reset.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: checksum is the 32-bit wrapping sum of every word accepted by imem_ack this session. It is cleared on start.
- Undefined: checksum is tied to 0 and no adder is inferred.

Test Plan:
- start, then I op=0010011 rd=1 rs1=0 f3=0 imm=5, in_last=0 -> addr 0 written 0x00500093, ack same cycle, in_ready high again 2 cycles after accept.
- S op=0100011 rs1=1 rs2=2 f3=010 imm=8 -> 0x0020A423 at addr 1. B op=1100011 rs1=1 rs2=2 f3=000 imm=0xFFFFFFFC -> 0xFE208EE3 at addr 2.
- J op=1101111 rd=1 imm=8, in_last=1 -> 0x008000EF at addr 3, then done=1, count=4, error=0. With macro, checksum equals the sum of the four words mod 2^32.
- Hold imem_ack=0 for 3 cycles in WRITE -> imem_we, imem_addr and imem_wdata stable, in_ready=0; completes on the 4th cycle.
- fmt=3'b110 -> 0x00000013 written, error=1. B imm=7 -> error=1. ADDR_WIDTH=2 with 5 bundles -> 4 writes, error=1, done=1, count=4.
- rst_n low during WRITE -> imem_we=0 asynchronously, all outputs at reset values. start afterward writes from BASE_ADDR.
